icache_dm16: RTL and testbench
==============================

# icache_dm16

- Direct-mapped, 16-frame, one-word-block instruction cache.
- Sits between the datapath's icache port (`imemREN`/`imemaddr` in, `ihit`/`imemload` out) and the memory controller's instruction port (`iREN`/`iaddr` out, `iwait`/`iload` in).
- Hits return the cached word in the same cycle as the request. Misses run a blocking fill FSM that fetches one word from memory, installs it, then re-looks-up the address.
- Free-running hit and miss counters support CPI/hit-rate measurement in the testbench.

## Interface
Parameters:
- `NSETS`, 16: number of frames; must be a power of two.
- `IDX_W`, 4: index width, log2(`NSETS`).

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `imemREN`  in  1  datapath instruction read request.
- `imemaddr`  in  32  instruction byte address (`word_t`); bits [1:0] ignored.
- `ihit`  out  1  requested word is valid on `imemload` this cycle.
- `imemload`  out  32  instruction word; 0 when `ihit` is low.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory read address, word-aligned.
- `iwait`  in  1  memory busy; `iload` is valid in a cycle where `iREN` is high and `iwait` is low.
- `iload`  in  32  memory read data.
- `hit_count`  out  32  cycles with `ihit` high.
- `miss_count`  out  32  fills started.

## Operation
Address split:
- tag = [31:IDX_W+2]
- index = [IDX_W+1:2]
- byte offset = [1:0]

Frame contents: valid bit, tag, 32-bit data.

FSM states, `IDLE` and `FILL`:
- **`IDLE`:**
  - Lookup is combinational: `ihit` = `imemREN` & valid[idx] & (tag[idx] == addr tag). On a hit, `imemload` = data[idx].
  - On `imemREN` & !hit: latch the word-aligned `imemaddr` into `miss_addr`, increment `miss_count`, and go to `FILL`.
- **`FILL`:**
  - Drive `iREN`=1 and `iaddr`=`miss_addr`.
  - When `iwait`=0: write valid=1, the tag and `iload` into the frame indexed by `miss_addr`, then go to `IDLE`.
  - `ihit` is 0 throughout `FILL`.

Other rules:
- The fill always completes to the latched `miss_addr`; memory requests are never aborted. If `imemaddr` changes mid-fill (branch redirect), the new address is looked up in `IDLE` after the fill. It may hit, or start a new miss.
- A fill overwrites whatever occupied the frame, whether valid or not (no replacement policy beyond direct mapping).
- `imemREN`=0 in `IDLE`: no lookup, `ihit`=0, no state change.
- `iREN`=0 and `iaddr`=0 in `IDLE`.
- Counters wrap modulo 2^32.
- `hit_count` increments on every cycle `ihit`=1, including repeated hits while the datapath stalls on the same address.

## Timing
Reset, sampled on a rising edge with `RST`=1:
- All valid bits 0, state `IDLE`, `miss_addr`=0, both counters 0.
- Next cycle: `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
- Tag and data arrays need not be cleared.

Reset mid-fill: state returns to `IDLE` and `iREN` drops the next cycle. The in-flight word is discarded and not written.

Hit latency: 0 cycles (combinational from `imemaddr`/`imemREN`).

Miss timing, with memory wait of W cycles:
- Cycle 0: miss detected.
- Cycles 1 to 1+W: `iREN` high.
- Cycle 1+W: `iwait`=0 and the frame is written.
- Cycle 2+W: `ihit`=1.
- Total miss penalty: W+2 cycles from request to `ihit`.

`iaddr` and `iREN` are registered-state-derived only; they never depend combinationally on `imemaddr`.

Simultaneous `RST` and fill completion: reset wins.

## Structure
- `word_t` comes from `cpu_types_pkg`.
- Add `icache_frame_t` (valid, tag[31-IDX_W-2:0], data word) and the `icache_state_t` enum {`IDLE`, `FILL`} to `cpu_types_pkg`.
- One module. The frame array is a flat register array of `icache_frame_t`, written only in `FILL` on `!iwait`.
- Top-level wiring binds `imemREN`/`imemaddr`/`ihit`/`imemload` to the icache modport of `datapath_cache_if`.

## Test plan
- Cold miss: reset; `imemREN`=1, `imemaddr`=0x00000040; memory W=2 returning 0x8C010004 -> `iREN` high for 3 cycles with `iaddr`=0x40, then `ihit`=1 with `imemload`=0x8C010004; `miss_count`=1.
- Hit then conflict: after the fill of 0x40, request 0x40 -> immediate hit. Request 0x00000080 (same index 0, different tag) -> miss and refill. Request 0x40 again -> miss; `miss_count`=3.
- Redirect during fill: miss on 0x10; change `imemaddr` to 0x20 at fill cycle 1 -> `iaddr` stays 0x10 for the whole fill; after the fill, 0x20 misses; frame 4 holds tag of 0x10.
- `imemREN` low: with `imemaddr`=0x44 and `imemREN`=0 for 5 cycles -> `ihit`=0, `iREN`=0, counters unchanged.
- Reset mid-fill: assert `RST` at W=3 fill cycle 2 -> `iREN`=0 the next cycle; re-request the same address -> miss (frame not installed).
- Hit counting: hold a cached address with `imemREN`=1 for 10 cycles -> `hit_count` increases by exactly 10; offset bits 0x41–0x43 hit the same frame as 0x40.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types.
//   word_t          - 32-bit machine word
//   icache_frame_t  - one direct-mapped icache frame (valid, tag, data)
//   icache_state_t  - icache fill FSM states
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_NSETS = 16;
    localparam int ICACHE_IDX_W = 4;
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/datapath_cache_if.sv
// datapath_cache_if: datapath <-> cache handshake bundle.
//   icache modport : imemREN/imemaddr in, ihit/imemload out (cache side)
//   dp modport     : mirror view for the datapath
// The system top binds icache_dm16's datapath-side ports to the icache modport.
interface datapath_cache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    modport icache (input imemREN, input imemaddr, output ihit, output imemload);
    modport dp     (output imemREN, output imemaddr, input ihit, input imemload);
endinterface

// File: rtl/icache_dm16.sv
// icache_dm16: direct-mapped, 16-frame, one-word-block instruction cache.
//   CLK, RST               clock, synchronous active-high reset
//   imemREN/imemaddr       datapath read request and byte address
//   ihit/imemload          same-cycle hit flag and word (0 when no hit)
//   iREN/iaddr             memory read request and word-aligned address
//   iwait/iload            memory busy flag and read data
//   hit_count/miss_count   free-running cycles-with-hit / fills-started counters
// Misses block in FILL until memory returns, install the word, then the
// current imemaddr is looked up again in IDLE.
module icache_dm16
    import cpu_types_pkg::*;
#(
    parameter int NSETS = ICACHE_NSETS,
    parameter int IDX_W = ICACHE_IDX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  word_t       imemaddr,
    output logic        ihit,
    output word_t       imemload,
    output logic        iREN,
    output word_t       iaddr,
    input  logic        iwait,
    input  word_t       iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int TAG_W = 32 - IDX_W - 2;

    icache_state_t state_q, state_d;
    word_t         miss_addr_q, miss_addr_d;
    icache_frame_t frames_q [NSETS];
    logic [31:0]   hit_count_q, miss_count_q;

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             lookup_match;
    logic             miss_start;
    logic             fill_we;
    logic [1:0]       unused_offset;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[31:IDX_W+2];
    assign fill_idx      = miss_addr_q[IDX_W+1:2];
    assign fill_tag      = miss_addr_q[31:IDX_W+2];
    assign unused_offset = imemaddr[1:0];

    assign lookup_match = frames_q[req_idx].valid && (frames_q[req_idx].tag == req_tag);

    // Next-state and outputs. Memory-side outputs depend only on registered
    // state so the memory port never sees a combinational path from imemaddr.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        ihit        = 1'b0;
        imemload    = '0;
        iREN        = 1'b0;
        iaddr       = '0;
        miss_start  = 1'b0;
        fill_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (imemREN) begin
                    if (lookup_match) begin
                        ihit     = 1'b1;
                        imemload = frames_q[req_idx].data;
                    end else begin
                        miss_start  = 1'b1;
                        miss_addr_d = {imemaddr[31:2], 2'b00};
                        state_d     = FILL;
                    end
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (ihit)       hit_count_q  <= hit_count_q + 32'd1;
            if (miss_start) miss_count_q <= miss_count_q + 32'd1;
        end
    end

    // Only valid bits are reset; tag/data are qualified by valid. A reset
    // coincident with fill completion discards the returning word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NSETS; i++) frames_q[i].valid <= 1'b0;
        end else if (fill_we) begin
            frames_q[fill_idx].valid <= 1'b1;
            frames_q[fill_idx].tag   <= fill_tag;
            frames_q[fill_idx].data  <= iload;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_dm16.sv
module tb_icache_dm16;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    // memory model: returns mem_data after mem_w busy cycles of iREN
    int unsigned wcnt = 0;
    int unsigned mem_w = 0;
    logic [31:0] mem_data = '0;

    icache_dm16 dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) wcnt <= iREN ? wcnt + 1 : 0;
    assign iwait = iREN && (wcnt < mem_w);
    assign iload = mem_data;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue a request and wait for ihit; lat counts cycles from request to hit.
    task automatic req(input logic [31:0] a, input int unsigned w, input logic [31:0] d,
                       output int lat, output logic [31:0] load, output int iren_n,
                       output logic addr_ok);
        logic done;
        @(posedge CLK); #1;
        imemREN = 1'b1; imemaddr = a; mem_w = w; mem_data = d;
        lat = 0; iren_n = 0; addr_ok = 1'b1; load = '0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (ihit) begin
                load = imemload;
                done = 1'b1;
            end else begin
                if (iREN) begin
                    iren_n++;
                    if (iaddr !== {a[31:2], 2'b00}) addr_ok = 1'b0;
                end
                @(posedge CLK); #1;
                lat++;
            end
        end
        if (!done) lat = -1;
    endtask

    // Start a miss, then assert RST during the 2nd fill cycle.
    task automatic rst_mid_fill(input logic [31:0] a, input int unsigned w);
        @(posedge CLK); #1;
        imemREN = 1'b1; imemaddr = a; mem_w = w; mem_data = 32'hBAD0BAD0;
        @(posedge CLK); #1;          // fill cycle 1
        @(posedge CLK); #1; RST = 1'b1;  // fill cycle 2
        @(posedge CLK); #1; RST = 1'b0; imemREN = 1'b0;
        @(negedge CLK);
        chk("rst_fill_iREN", {31'b0, iREN}, 32'd0);
        chk("rst_fill_miss_count", miss_count, 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        int unsigned w;
        logic [31:0] mdata;
        int          lat;
        logic [31:0] load;
        logic [31:0] mc;
        int          iren;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int lat, iren_n, n;
        logic [31:0] load, hc0;
        logic addr_ok;

        tbl[0]  = '{32'h0000_0040, 2, 32'h8C01_0004, 4, 32'h8C01_0004, 1, 3}; // cold miss
        tbl[1]  = '{32'h0000_0040, 0, 32'h0,         0, 32'h8C01_0004, 1, 0}; // hit
        tbl[2]  = '{32'h0000_0080, 1, 32'h1111_1111, 3, 32'h1111_1111, 2, 2}; // conflict idx0
        tbl[3]  = '{32'h0000_0040, 0, 32'h2222_2222, 2, 32'h2222_2222, 3, 1}; // evicted -> miss
        tbl[4]  = '{32'h0000_0043, 0, 32'h0,         0, 32'h2222_2222, 3, 0}; // offset bits
        tbl[5]  = '{32'h0000_0041, 0, 32'h0,         0, 32'h2222_2222, 3, 0};
        tbl[6]  = '{32'h0000_0042, 0, 32'h0,         0, 32'h2222_2222, 3, 0};
        tbl[7]  = '{32'h0000_0080, 0, 32'h3333_3333, 2, 32'h3333_3333, 4, 1};
        tbl[8]  = '{32'hFFFF_FFFC, 1, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 5, 2}; // idx 15, max tag
        tbl[9]  = '{32'hFFFF_FFFC, 0, 32'h0,         0, 32'hDEAD_BEEF, 5, 0};
        tbl[10] = '{32'h0000_003C, 0, 32'h4444_4444, 2, 32'h4444_4444, 6, 1}; // idx 15, tag 0

        // reset state
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_ihit", {31'b0, ihit}, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iREN", {31'b0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);

        // cold miss on 0x40 shows imemload 0 while not hitting
        @(posedge CLK); #1; imemREN = 1'b1; imemaddr = 32'h40;
        @(negedge CLK);
        chk("miss_imemload_zero", imemload, 32'd0);
        @(posedge CLK); #1; RST = 1'b1; imemREN = 1'b0;
        @(posedge CLK); #1; RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 11; i++) begin
            req(tbl[i].addr, tbl[i].w, tbl[i].mdata, lat, load, iren_n, addr_ok);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_imemload", i), load, tbl[i].load);
            chk($sformatf("v%0d_miss_count", i), miss_count, tbl[i].mc);
            chk($sformatf("v%0d_iren_cycles", i), iren_n, tbl[i].iren);
            chk($sformatf("v%0d_iaddr", i), {31'b0, addr_ok}, 32'd1);
        end
        @(posedge CLK); #1; imemREN = 1'b0;
        @(negedge CLK);
        chk("table_hit_count", hit_count, 32'd11);

        // imemREN low: no lookup, no activity, counters frozen
        imemaddr = 32'h44;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("ren_low_ihit", {31'b0, ihit}, 32'd0);
            chk("ren_low_iREN", {31'b0, iREN}, 32'd0);
        end
        chk("ren_low_hit_count", hit_count, 32'd11);
        chk("ren_low_miss_count", miss_count, 32'd6);

        // redirect during fill: 0x10 fill completes, then 0x20 misses
        @(posedge CLK); #1; imemREN = 1'b1; imemaddr = 32'h10; mem_w = 2; mem_data = 32'h5555_5555;
        @(posedge CLK); #1; imemaddr = 32'h20;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (!iREN) break;
            n++;
            chk("redir_iaddr", iaddr, 32'h10);
            chk("redir_ihit", {31'b0, ihit}, 32'd0);
            @(posedge CLK); #1;
        end
        chk("redir_fill_cycles", n, 32'd3);
        chk("redir_new_addr_miss", {31'b0, ihit}, 32'd0);
        req(32'h20, 0, 32'h6666_6666, lat, load, iren_n, addr_ok);
        chk("redir_0x20_lat", lat, 32'd1);
        chk("redir_0x20_load", load, 32'h6666_6666);
        req(32'h10, 0, 32'hFFFF_0000, lat, load, iren_n, addr_ok);
        chk("redir_0x10_hit_lat", lat, 32'd0);
        chk("redir_0x10_load", load, 32'h5555_5555);
        chk("redir_miss_count", miss_count, 32'd8);

        // reset coincident with fill completion: word must not be installed
        rst_mid_fill(32'h48, 1);
        req(32'h48, 0, 32'h9999_9999, lat, load, iren_n, addr_ok);
        chk("rst_win_lat", lat, 32'd2);
        chk("rst_win_load", load, 32'h9999_9999);
        // reset mid-fill with W=3
        rst_mid_fill(32'h44, 3);
        req(32'h44, 0, 32'h8888_8888, lat, load, iren_n, addr_ok);
        chk("rst_mid_lat", lat, 32'd2);
        chk("rst_mid_load", load, 32'h8888_8888);
        chk("rst_mid_miss_count", miss_count, 32'd1);

        // hit counting over 10 held cycles, cycling offset bits
        @(posedge CLK); #1; imemREN = 1'b0;
        @(negedge CLK);
        hc0 = hit_count;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1; imemREN = 1'b1; imemaddr = 32'h44 + (i % 4);
            @(negedge CLK);
            chk("hold_ihit", {31'b0, ihit}, 32'd1);
            chk("hold_load", imemload, 32'h8888_8888);
        end
        @(posedge CLK); #1; imemREN = 1'b0;
        @(negedge CLK);
        chk("hold_hit_delta", hit_count - hc0, 32'd10);
        chk("hold_miss_count", miss_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
